// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, load/store and memory buses of mem_port_arbiter
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_ack;
    logic [DATA_W-1:0] i_rdata;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W/8-1:0] d_wstrb;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W/8-1:0] mem_wstrb;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, mem_rdata,
        output i_ack, i_rdata, d_ack, d_rdata, mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb, busy
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, mem_rdata,
        input  i_ack, i_rdata, d_ack, d_rdata, mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: one-at-a-time I/D arbiter for a shared single-port memory; ARB_STARVE_GUARD_EN bounds D-over-I starvation
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input logic              clk,
    input logic              rst,
    mem_port_arbiter_if.slave bus
);
    localparam int CW = $clog2(MEM_LAT + 1);
    localparam int SW = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            r_state;
    logic [CW-1:0]     r_cnt;
    logic              r_gnt_d;
    logic              r_busy;
    logic              r_i_ack;
    logic              r_d_ack;
    logic [DATA_W-1:0] r_i_rdata;
    logic [DATA_W-1:0] r_d_rdata;
    logic              r_mem_en;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [SW-1:0]     r_mem_wstrb;
    logic              w_pick_i;

    if (MEM_LAT < 1 || DATA_W % 8 != 0 || STARVE_MAX < 0) begin : g_bad_cfg
        $error("mem_port_arbiter: illegal parameter set");
    end

`ifdef ARB_STARVE_GUARD_EN
    localparam int SCW = $clog2(STARVE_MAX + 2);
    logic [SCW-1:0] r_starve;
    assign w_pick_i = bus.i_req && (!bus.d_req || r_starve == SCW'(STARVE_MAX));
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_starve <= '0;
        end else if (r_state == IDLE) begin
            if (!bus.i_req || w_pick_i) r_starve <= '0;
            else if (bus.d_req) r_starve <= r_starve + 1'b1;
        end
    end
`else
    assign w_pick_i = bus.i_req && !bus.d_req;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_gnt_d     <= 1'b0;
            r_busy      <= 1'b0;
            r_i_ack     <= 1'b0;
            r_d_ack     <= 1'b0;
            r_i_rdata   <= '0;
            r_d_rdata   <= '0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_wstrb <= '0;
        end else begin
            r_mem_en <= 1'b0;
            r_i_ack  <= 1'b0;
            r_d_ack  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.i_req || bus.d_req) begin
                        r_state     <= ISSUE;
                        r_busy      <= 1'b1;
                        r_gnt_d     <= !w_pick_i;
                        r_mem_en    <= 1'b1;
                        r_mem_we    <= !w_pick_i && bus.d_we;
                        r_mem_addr  <= w_pick_i ? bus.i_addr : bus.d_addr;
                        r_mem_wdata <= w_pick_i ? '0 : bus.d_wdata;
                        r_mem_wstrb <= w_pick_i ? '0 : bus.d_wstrb;
                    end
                end
                ISSUE: begin
                    if (r_mem_we) begin
                        r_state <= RESP;
                        r_d_ack <= 1'b1;
                    end else begin
                        r_state <= WAIT;
                        r_cnt   <= CW'(MEM_LAT);
                    end
                end
                WAIT: begin
                    r_cnt <= r_cnt - 1'b1;
                    // mem_rdata is valid in the last WAIT cycle, when the count is about to expire
                    if (r_cnt == CW'(1)) begin
                        r_state <= RESP;
                        r_i_ack <= !r_gnt_d;
                        r_d_ack <= r_gnt_d;
                        if (r_gnt_d) r_d_rdata <= bus.mem_rdata;
                        else r_i_rdata <= bus.mem_rdata;
                    end
                end
                RESP: begin
                    r_state     <= IDLE;
                    r_busy      <= 1'b0;
                    r_mem_we    <= 1'b0;
                    r_mem_addr  <= '0;
                    r_mem_wdata <= '0;
                    r_mem_wstrb <= '0;
                end
            endcase
        end
    end

    assign bus.i_ack     = r_i_ack;
    assign bus.i_rdata   = r_i_rdata;
    assign bus.d_ack     = r_d_ack;
    assign bus.d_rdata   = r_d_rdata;
    assign bus.mem_en    = r_mem_en;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.mem_wstrb = r_mem_wstrb;
    assign bus.busy      = r_busy;
endmodule
